// File: rtl/pulse_conditioner_if.sv
// Signal bundle between a pulse source/consumer and pulse_conditioner.
// The master drives the raw pulse and edge selection; the conditioner returns its outputs.
interface pulse_conditioner_if;
  logic       sig_in;
  logic [1:0] edge_sel_in;
  logic       pulse_out;
  logic       level_out;
  logic [7:0] drop_cnt_out;
  logic       active_led_out;

  modport master (
    output sig_in,
    output edge_sel_in,
    input  pulse_out,
    input  level_out,
    input  drop_cnt_out,
    input  active_led_out
  );

  modport slave (
    input  sig_in,
    input  edge_sel_in,
    output pulse_out,
    output level_out,
    output drop_cnt_out,
    output active_led_out
  );
endinterface

// File: rtl/pulse_conditioner.sv
// Synchronises and de-glitches a raw pulse input, then emits one strobe per selected edge
// with holdoff spacing, a saturating drop counter and a stretched active-low activity LED.
module pulse_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 16,
  parameter int HOLDOFF_CYCLES = 100,
  parameter int STRETCH_CYCLES = 10_000_000
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  pulse_conditioner_if.slave bus
);

  localparam int FLT_W  = $clog2(FILTER_CYCLES) + 1;
  localparam int HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam int LED_W  = $clog2(STRETCH_CYCLES + 1);

  localparam logic [FLT_W-1:0]  FLT_LAST  = FLT_W'(FILTER_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [LED_W-1:0]  LED_LOAD  = LED_W'(STRETCH_CYCLES);
  localparam logic [7:0]        DROP_MAX  = 8'hFF;

  logic              sync_reg [SYNC_STAGES];
  logic              sync_s;
  logic              level_reg;
  logic [FLT_W-1:0]  flt_cnt_reg;
  logic              level_change;
  logic              ev_sel_reg;
  logic              ev_sel_next;
  logic              accept;
  logic              drop;
  logic              pulse_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic [7:0]        drop_cnt_reg;
  logic [7:0]        drop_cnt_next;
  logic [LED_W-1:0]  led_cnt_reg;
  logic [LED_W-1:0]  led_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) sync_reg[gi] <= 1'b0;
          else           sync_reg[gi] <= bus.sig_in;
        end
      end else begin : g_chain
        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) sync_reg[gi] <= 1'b0;
          else           sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign sync_s       = sync_reg[SYNC_STAGES-1];
  assign level_change = (sync_s != level_reg) && (flt_cnt_reg == FLT_LAST);

  // Any cycle of agreement with the accepted level restarts the stability count.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      level_reg   <= 1'b0;
      flt_cnt_reg <= '0;
    end else if (sync_s == level_reg) begin
      flt_cnt_reg <= '0;
    end else if (level_change) begin
      level_reg   <= sync_s;
      flt_cnt_reg <= '0;
    end else begin
      flt_cnt_reg <= flt_cnt_reg + 1'b1;
    end
  end

  // Edge selection is sampled on the edge that updates the level; bit 0 rising, bit 1 falling.
  always_comb begin
    ev_sel_next = 1'b0;
    if (level_change)
      ev_sel_next = sync_s ? bus.edge_sel_in[0] : bus.edge_sel_in[1];
  end

  assign accept = ev_sel_reg && (hold_cnt_reg == '0);
  assign drop   = ev_sel_reg && (hold_cnt_reg != '0);

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (accept)
      hold_cnt_next = HOLD_LOAD;
    else if (hold_cnt_reg != '0)
      hold_cnt_next = hold_cnt_reg - 1'b1;

    drop_cnt_next = drop_cnt_reg;
    if (drop && (drop_cnt_reg != DROP_MAX))
      drop_cnt_next = drop_cnt_reg + 1'b1;

    led_cnt_next = led_cnt_reg;
    if (accept)
      led_cnt_next = LED_LOAD;
    else if (led_cnt_reg != '0)
      led_cnt_next = led_cnt_reg - 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ev_sel_reg   <= 1'b0;
      pulse_reg    <= 1'b0;
      hold_cnt_reg <= '0;
      drop_cnt_reg <= '0;
      led_cnt_reg  <= '0;
    end else begin
      ev_sel_reg   <= ev_sel_next;
      pulse_reg    <= accept;
      hold_cnt_reg <= hold_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
      led_cnt_reg  <= led_cnt_next;
    end
  end

  assign bus.pulse_out      = pulse_reg;
  assign bus.level_out      = level_reg;
  assign bus.drop_cnt_out   = drop_cnt_reg;
  assign bus.active_led_out = (led_cnt_reg == '0);

endmodule

// File: tb/tb_pulse_conditioner.sv
// Bench for pulse_conditioner: two instances (holdoff 100 and holdoff 0) share one input and
// are compared every cycle against a timestamp-based model, plus directed literal checks.
module tb_pulse_conditioner;

  localparam int SYNC    = 2;
  localparam int FILT    = 16;
  localparam int STRETCH = 50;
  localparam int HOLD_H  = 100;
  localparam int HOLD_Z  = 0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig   = 1'b0;
  logic [1:0] es_h  = 2'b00;
  logic [1:0] es_z  = 2'b00;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ph[$];
  int pz[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_conditioner_if ifh ();
  pulse_conditioner_if ifz ();

  assign ifh.sig_in      = sig;
  assign ifz.sig_in      = sig;
  assign ifh.edge_sel_in = es_h;
  assign ifz.edge_sel_in = es_z;

  pulse_conditioner #(
    .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .HOLDOFF_CYCLES(HOLD_H), .STRETCH_CYCLES(STRETCH)
  ) dut_h (
    .clk_in(clk), .rst_n_in(rst_n), .bus(ifh)
  );

  pulse_conditioner #(
    .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .HOLDOFF_CYCLES(HOLD_Z), .STRETCH_CYCLES(STRETCH)
  ) dut_z (
    .clk_in(clk), .rst_n_in(rst_n), .bus(ifz)
  );

  task automatic check(input string tag, input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d (cycle %0d)", tag, name, act, exp, cyc);
    end
  endtask

  // Reference model: filtered level from run lengths, pulses as timestamps, LED from time since pulse.
  bit m_pipe [SYNC];
  bit m_lvl;
  int m_streak;
  int m_mc;
  bit m_pend [2];
  bit m_has  [2];
  int m_last [2];
  int m_drop [2];

  function automatic int hold_of(input int i);
    return (i == 0) ? HOLD_H : HOLD_Z;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) m_pipe[k] = 1'b0;
    m_lvl = 1'b0; m_streak = 0; m_mc = 0;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 1'b0; m_has[i] = 1'b0; m_last[i] = 0; m_drop[i] = 0;
    end
  endtask

  task automatic model_step();
    bit s_pre;
    bit ev;
    logic [1:0] es;
    m_mc++;
    s_pre = m_pipe[SYNC-1];
    for (int k = SYNC-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = sig;
    ev = 1'b0;
    if (s_pre != m_lvl) begin
      m_streak++;
      if (m_streak == FILT) begin
        m_lvl = s_pre; m_streak = 0; ev = 1'b1;
      end
    end else begin
      m_streak = 0;
    end
    for (int i = 0; i < 2; i++) begin
      es = (i == 0) ? es_h : es_z;
      if (m_pend[i]) begin
        if (!m_has[i] || (m_mc - m_last[i]) > hold_of(i)) begin
          m_has[i] = 1'b1; m_last[i] = m_mc;
        end else if (m_drop[i] < 255) begin
          m_drop[i]++;
        end
      end
      m_pend[i] = ev && (m_lvl ? es[0] : es[1]);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  task automatic cmp_inst(input string tag, input int i, input logic p, input logic l,
                          input logic led, input logic [7:0] d);
    int exp_p;
    int exp_led;
    exp_p   = (m_has[i] && m_last[i] == m_mc) ? 1 : 0;
    exp_led = (m_has[i] && (m_mc - m_last[i]) < STRETCH) ? 0 : 1;
    check(tag, "pulse_out", int'(p), exp_p);
    check(tag, "level_out", int'(l), int'(m_lvl));
    check(tag, "active_led_out", int'(led), exp_led);
    check(tag, "drop_cnt_out", int'(d), m_drop[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_inst("H", 0, ifh.pulse_out, ifh.level_out, ifh.active_led_out, ifh.drop_cnt_out);
      cmp_inst("Z", 1, ifz.pulse_out, ifz.level_out, ifz.active_led_out, ifz.drop_cnt_out);
      if (ifh.pulse_out) ph.push_back(cyc);
      if (ifz.pulse_out) pz.push_back(cyc);
    end
  end

  task automatic check_reset_vals(input string tag);
    check(tag, "rst pulse_out H", int'(ifh.pulse_out), 0);
    check(tag, "rst level_out H", int'(ifh.level_out), 0);
    check(tag, "rst drop_cnt H", int'(ifh.drop_cnt_out), 0);
    check(tag, "rst led H", int'(ifh.active_led_out), 1);
    check(tag, "rst pulse_out Z", int'(ifz.pulse_out), 0);
    check(tag, "rst led Z", int'(ifz.active_led_out), 1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(tag);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Counts edges from the first edge after the call; sig must already be (or just become) high.
  task automatic measure(input string tag);
    int first_p = 0;
    int first_l = 0;
    int np      = 0;
    int led_low = 0;
    for (int e = 1; e <= 90; e++) begin
      @(posedge clk);
      #1;
      if (ifh.pulse_out) begin
        np++;
        if (first_p == 0) first_p = e;
      end
      if (ifh.level_out && first_l == 0) first_l = e;
      if (!ifh.active_led_out) led_low++;
    end
    check(tag, "pulse edge", first_p, 19);
    check(tag, "pulse count", np, 1);
    check(tag, "level edge", first_l, 18);
    check(tag, "led low cycles", led_low, STRETCH);
    $display("%s: pulse at edge %0d, level at edge %0d, led low %0d", tag, first_p, first_l, led_low);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    do_reset("idle");
    repeat (1000) @(negedge clk);
    #3;
    check("idle", "pulses", ph.size() + pz.size(), 0);
    check("idle", "led", int'(ifh.active_led_out), 1);
    $display("idle: %0d cycles without activity", 1000);

    // Latency and LED stretch
    es_h = 2'b01; es_z = 2'b01;
    do_reset("latency");
    @(negedge clk);
    sig = 1'b1;
    measure("latency");
    sig = 1'b0;
    repeat (40) @(negedge clk);

    // Glitch rejection
    do_reset("glitch");
    ph.delete(); pz.delete();
    @(negedge clk);
    sig = 1'b1;
    repeat (15) @(negedge clk);
    sig = 1'b0;
    repeat (30) @(negedge clk);
    #3;
    check("glitch", "pulses after 15-cycle", ph.size(), 0);
    @(negedge clk);
    sig = 1'b1;
    repeat (16) @(negedge clk);
    sig = 1'b0;
    repeat (40) @(negedge clk);
    #3;
    check("glitch", "pulses after 16-cycle H", ph.size(), 1);
    check("glitch", "pulses after 16-cycle Z", pz.size(), 1);
    $display("glitch: %0d pulse(s)", ph.size());

    // Both edges, no holdoff; the holdoff instance is deselected
    es_h = 2'b00; es_z = 2'b11;
    do_reset("both");
    ph.delete(); pz.delete();
    @(negedge clk);
    repeat (5) begin
      sig = 1'b1;
      repeat (40) @(negedge clk);
      sig = 1'b0;
      repeat (40) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    #3;
    check("both", "pulse count", pz.size(), 10);
    for (int k = 1; k < pz.size(); k++) check("both", "spacing", pz[k] - pz[k-1], 40);
    check("both", "deselected pulses", ph.size(), 0);
    check("both", "deselected drops", int'(ifh.drop_cnt_out), 0);
    $display("both: %0d pulses", pz.size());

    // Holdoff and drop saturation
    es_h = 2'b01; es_z = 2'b01;
    do_reset("holdoff");
    ph.delete(); pz.delete();
    @(negedge clk);
    repeat (300) begin
      sig = 1'b1;
      repeat (20) @(negedge clk);
      sig = 1'b0;
      repeat (20) @(negedge clk);
    end
    #3;
    check("holdoff", "accepted", ph.size(), 100);
    for (int k = 1; k < ph.size(); k++) check("holdoff", "spacing", ph[k] - ph[k-1], 120);
    check("holdoff", "drop count", int'(ifh.drop_cnt_out), 200);
    $display("holdoff: %0d accepted, %0d dropped", ph.size(), ifh.drop_cnt_out);
    repeat (200) begin
      @(negedge clk);
      sig = 1'b1;
      repeat (19) @(negedge clk);
      sig = 1'b0;
      repeat (20) @(negedge clk);
    end
    #3;
    check("holdoff", "drop saturated", int'(ifh.drop_cnt_out), 255);
    $display("holdoff: drop count %0d after extended run", ifh.drop_cnt_out);

    // Reset mid-holdoff with the input held high
    do_reset("midrst-pre");
    @(negedge clk);
    sig = 1'b1;
    repeat (19 + 40) @(negedge clk);
    #3;
    check("midrst", "level before", int'(ifh.level_out), 1);
    check("midrst", "led before", int'(ifh.active_led_out), 0);
    do_reset("midrst");
    measure("midrst");

    // Randomized run with occasional edge-select changes and resets
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 3) == 0) es_h = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) es_z = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) do_reset("random");
      @(negedge clk);
      sig = ~sig;
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end
    repeat (200) @(negedge clk);
    $display("random: done at cycle %0d", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
